// File: rtl/link_arbiter.sv
// Round-robin arbiter that shares one 4-phase req/ack byte link among NUM_REQ requesters.
// Each grant covers one whole handshake and forwards exactly one byte to the slave.
`timescale 1ns/1ps
module link_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        m_req,
   input  logic [NUM_REQ*DATA_W-1:0] m_data,
   output logic [NUM_REQ-1:0]        m_ack,
   output logic                      s_req,
   output logic [DATA_W-1:0]         s_data,
   input  logic                      s_ack,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic [CNT_W-1:0]          xfer_count
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FWD   = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]       state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] gidx;
   logic             sel_found;
   logic [PTR_W-1:0] sel_idx;

   // Index arithmetic modulo NUM_REQ; off is always below NUM_REQ so one subtract suffices.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return PTR_W'(sum);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First requesting index at or after ptr, searching upward with wrap.
   always_comb begin
      logic [PTR_W-1:0] cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(ptr, k);
         if (!sel_found && m_req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         gidx       <= '0;
         m_ack      <= '0;
         s_req      <= 1'b0;
         s_data     <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         xfer_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  gidx   <= sel_idx;
                  grant  <= onehot(sel_idx);
                  s_data <= m_data[sel_idx*DATA_W +: DATA_W];
                  s_req  <= 1'b1;
                  busy   <= 1'b1;
                  state  <= FWD;
               end
            end
            // Committed once granted: a dropped m_req here does not cancel the transfer.
            FWD: begin
               if (s_ack) begin
                  m_ack[gidx] <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (!m_req[gidx]) begin
                  s_req <= 1'b0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!s_ack) begin
                  m_ack      <= '0;
                  grant      <= '0;
                  busy       <= 1'b0;
                  xfer_count <= xfer_count + 1'b1;
                  ptr        <= wrap_add(gidx, 1);
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
